// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the MSB-first serial receive path.
// Frame length depends on whether SIPO_RX_PARITY_EN is defined when the top is built.
package sipo_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DW_DEFAULT = 9;

  // Number of serial bits in one frame: data bits plus an optional trailing parity bit.
  function automatic int frame_len(input int dw, input bit parity_en);
    int fl;
    if (parity_en) begin
      fl = dw + 1;
    end else begin
      fl = dw;
    end
    return fl;
  endfunction

endpackage

// File: rtl/sipo_msb_rx_bit_counter.sv
// Clearable up-counter with a terminal-count flag against a programmable last value.
// Shared with the transmit-side control, so it carries no frame knowledge of its own.
module bit_counter
  import sipo_rx_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] last,
  output logic          tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CW{1'b0}};
    end else if (inc) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == last);

endmodule

// File: rtl/sipo_msb_rx.sv
// MSB-first serial-in/parallel-out receiver with start/shift strobes and a one-cycle valid.
// Optional even-parity trailer enabled by defining SIPO_RX_PARITY_EN.
module sipo_msb_rx
  import sipo_rx_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enb,
  input  logic          start,
  input  logic          shift,
  input  logic          inp,
  output logic [DW-1:0] out,
  output logic          valid,
  output logic          busy
`ifdef SIPO_RX_PARITY_EN
  ,
  output logic          parity_err
`endif
);

`ifdef SIPO_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int            CW   = $clog2(DW + 2);
  localparam int            FL   = frame_len(DW, PAR_EN);
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] sreg_q, sreg_d;
  logic [DW-1:0] out_q, out_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          cnt_clr_s, cnt_inc_s, cnt_tc_s;
`ifdef SIPO_RX_PARITY_EN
  logic          perr_q, perr_d;
`else
  logic          unused_s;
  assign unused_s = sreg_q[DW-1];
`endif

  bit_counter #(.CW(CW)) u_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .last  (LAST),
    .tc    (cnt_tc_s)
  );

  // Next-state, shift and capture logic; nothing moves while enb is low.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    out_d     = out_q;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
`ifdef SIPO_RX_PARITY_EN
    perr_d    = perr_q;
`endif
    if (enb) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = SHIFT;
            cnt_clr_s = 1'b1;
          end else begin
            state_d   = IDLE;
          end
        end
        SHIFT: begin
          if (shift) begin
            sreg_d = {sreg_q[DW-2:0], inp};
            if (cnt_tc_s) begin
              state_d   = DONE;
              cnt_clr_s = 1'b1;
`ifdef SIPO_RX_PARITY_EN
              // Final bit is the parity trailer: data already sits whole in sreg.
              out_d  = sreg_q;
              perr_d = (^sreg_q) ^ inp;
`else
              out_d  = {sreg_q[DW-2:0], inp};
`endif
            end else begin
              cnt_inc_s = 1'b1;
            end
          end else begin
            state_d = SHIFT;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    valid_d = (state_d == DONE);
    busy_d  = (state_d == SHIFT);
  end

  // State, data and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= {DW{1'b1}};
      out_q   <= {DW{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef SIPO_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
`ifdef SIPO_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: doc/sipo_msb_rx.md
Name: sipo_msb_rx

Overview:
- Serial-in/parallel-out receiver. It is the receive end of our MSB-first serial shift link.
- Collects a frame of DW bits, MSB first, from a single serial line and presents it as a parallel word with a one-cycle valid flag.
- Framed by an explicit start strobe and paced by a per-bit shift strobe, the same strobes that drive the transmitting shift register.
- Sits on the far side of the transmitter; one cable bit maps to one accepted shift.

Parameters:
- DW, 9, data word width in bits (DW >= 2).
- CW, $clog2(DW+2), localparam: bit-counter width, sized to cover the parity build as well.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous reset, active low.
- enb  input  1  global enable; when low, all state freezes.
- start  input  1  frame start strobe; honoured only in IDLE.
- shift  input  1  bit strobe; the serial bit is sampled on an enabled edge with shift=1 in SHIFT.
- inp  input  1  serial data line; idle level is 1.
- out  output  DW  last complete received word.
- valid  output  1  high while in DONE: out holds a fresh word.
- busy  output  1  high while in SHIFT.
- parity_err  output  1  present only with SIPO_RX_PARITY_EN.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE
  - shift register = all ones
  - bit counter = 0
  - out = 0
  - valid = 0, busy = 0, parity_err = 0
- Every transition below requires enb=1 at the clock edge. With enb=0, state, counter, shift register and out all hold, and outputs hold their values, including valid=1 in DONE.
- IDLE:
  - start=1 -> SHIFT, counter cleared to 0.
  - shift in the same cycle is ignored; no bit is sampled.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each edge with shift=1: shift register <= {sreg[DW-2:0], inp}, counter +1.
  - On the accepted shift that completes the frame (counter == FL-1, where FL = DW, or DW+1 with parity):
    - out <= the assembled word, including that final bit, registered on the same edge.
    - state -> DONE.
    - counter -> 0.
  - shift=0 -> hold; gaps of any length are allowed between bits.
  - start in SHIFT is ignored and does not restart the frame.
- DONE:
  - valid=1 for exactly one enabled cycle, then -> IDLE unconditionally.
  - start in DONE is ignored; a back-to-back frame needs start in the following IDLE cycle.
- Latency: valid rises the cycle after the final accepted shift edge.
- out holds its value until the next complete frame. An aborted frame never alters out.
- Reset mid-frame: immediate return to IDLE, partial bits discarded, out cleared to 0.
- Bit ordering: the first accepted bit lands in out[DW-1] and the last in out[0].
- Loopback: the transmitter loaded on the same edge that this block sees start, followed by DW common shift strobes, reproduces the loaded word.

Optional Feature:
- Macro: SIPO_RX_PARITY_EN.
- Defined:
  - Frame length is DW+1.
  - The extra final bit is an even-parity bit covering the DW data bits.
  - The parity bit is not placed in out.
  - parity_err is registered on the same edge as out: 1 if the XOR of the data bits and the parity bit is 1.
  - parity_err holds its value until the next frame completes; reset value is 0.
- Undefined:
  - Frame length is DW.
  - The parity_err port and its logic are absent.

Decomposition:
- Package sipo_rx_pkg:
  - state enum typedef state_e {IDLE, SHIFT, DONE}, 2-bit logic.
  - DW_DEFAULT = 9.
  - Helper function for frame length selection.
- Sub-module bit_counter (CW wide): clear, increment and terminal-count flag. Natural for reuse by the transmitter-side control.
- The FSM, shift register and output register stay in sipo_msb_rx.

Test Plan:
- Reset: assert reset mid-simulation -> out=9'h000, valid=0, busy=0, state IDLE; shift register reads 9'h1FF internally.
- Basic frame: start, then 9 consecutive shifts carrying 1,1,0,1,0,0,1,0,1 -> out=9'h1A5 on the edge of the 9th shift; valid=1 for exactly the next cycle; busy=1 during the shifts.
- Gapped/enable: same word with 0–3 idle cycles between shifts, plus enb=0 for 4 cycles mid-frame and during DONE -> out=9'h1A5, no lost or extra bits; valid held high while enb=0 in DONE.
- Abort: start, 5 shifts, reset pulse, then a new full frame of 9'h0F0 -> out=9'h0F0; no residue from the partial frame; start asserted during SHIFT has no effect.
- Loopback: random words from the transmitter, DW=9 and DW=16, with shared start/shift strobes -> out equals the loaded word for 1000 frames, including back-to-back frames.
- Parity (macro defined): 9'h1A5 followed by parity bit 1 -> parity_err=0; same frame with parity bit 0 -> parity_err=1; out=9'h1A5 in both cases.
